spi_slave_ctrl: RTL and testbench

Parametrised SPI slave for the FPGA fabric that generalises the byte-only mode-0 slave to any word width and all four SPI modes (CPOL/CPHA). It adds valid/ready handshakes on both the receive and transmit sides, plus overrun and underrun detection. It sits between the external SPI pins and the on-chip message logic. All SPI inputs are oversampled in the system clock domain.

---
 rtl/spi_slave_ctrl.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// spi_slave_ctrl
//   SPI slave for any word width (4..32) and any SPI mode (CPOL/CPHA). All pin
//   inputs are oversampled in the clk domain. The receive side presents whole
//   words on a valid/ready handshake. The transmit side takes words through a
//   one-entry holding register, also with valid/ready.
//
//   Optional feature macro: SPI_SLAVE_CTRL_ECHO_EN
//     defined   -> an empty holding register at load time sends rx_data (echo)
//     undefined -> an empty holding register at load time sends all zeros
//
// Ports
//   clk, rst_n    system clock, synchronous active-low reset
//   SCK, SSEL     SPI clock and active-low select from master (asynchronous)
//   MOSI          master-out data (asynchronous)
//   MISO, miso_oe slave-out data (MSB first) and pad output enable
//   rx_data/rx_valid/rx_ready  received word handshake
//   rx_overrun    sticky, word completed while previous one unconsumed
//   tx_data/tx_valid/tx_ready  transmit word handshake into holding register
//   tx_underrun   one-cycle pulse, word load found holding register empty
//   frame_active  synchronised SSEL active
// -----------------------------------------------------------------------------
module spi_slave_ctrl #(
  parameter int WIDTH = 8,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SCK,
  input  logic             SSEL,
  input  logic             MOSI,
  output logic             MISO,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_active
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [2:0]       sck_sync;
  logic [2:0]       ssel_sync;
  logic [1:0]       mosi_sync;
  logic [1:0]       settle_cnt;
  logic             armed;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic [WIDTH-1:0] fill_word;

  logic leading_edge, trailing_edge, sample_edge, drive_edge;
  logic arm_ok, frame_start, frame_end, active, in_frame;
  logic rx_shift_en, word_done, tx_load, tx_shift_en;

`ifdef SPI_SLAVE_CTRL_ECHO_EN
  assign fill_word = rx_data;
`else
  assign fill_word = '0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // can leave a value held, which would infer a latch.
    leading_edge  = 1'b0;
    trailing_edge = 1'b0;
    sample_edge   = 1'b0;
    drive_edge    = 1'b0;
    arm_ok        = 1'b0;
    frame_start   = 1'b0;
    frame_end     = 1'b0;
    active        = 1'b0;
    in_frame      = 1'b0;
    rx_shift_en   = 1'b0;
    word_done     = 1'b0;
    tx_load       = 1'b0;
    tx_shift_en   = 1'b0;

    // Edges are judged on the two oldest SCK flops; the idle level is CPOL.
    leading_edge  = (sck_sync[2] == CPOL) && (sck_sync[1] != CPOL);
    trailing_edge = (sck_sync[2] != CPOL) && (sck_sync[1] == CPOL);
    sample_edge   = CPHA ? trailing_edge : leading_edge;
    drive_edge    = CPHA ? leading_edge  : trailing_edge;

    // After reset the SSEL chain holds its reset value, not the pin. Frames are
    // only recognised once real SSEL-high data has reached the oldest flop, so
    // a reset in the middle of a frame ignores the rest of that frame.
    arm_ok      = armed || ((settle_cnt == 2'd3) && ssel_sync[2]);
    frame_start = arm_ok && ssel_sync[2] && !ssel_sync[1];
    frame_end   = armed && !ssel_sync[2] && ssel_sync[1];
    active      = armed && !ssel_sync[2];
    in_frame    = active && !frame_end;

    rx_shift_en = in_frame && sample_edge;
    word_done   = rx_shift_en && (bitcnt == LAST_BIT);
    tx_load     = frame_start || (in_frame && drive_edge && (bitcnt == '0));
    tx_shift_en = in_frame && drive_edge && (bitcnt != '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop sees
    // the pre-edge value of every other flop, independent of statement order.
    if (!rst_n) begin
      sck_sync    <= {3{CPOL}};
      ssel_sync   <= 3'b111;
      mosi_sync   <= 2'b00;
      settle_cnt  <= 2'd0;
      armed       <= 1'b0;
      bitcnt      <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_shift    <= '0;
      tx_underrun <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[1:0], SCK};
      ssel_sync <= {ssel_sync[1:0], SSEL};
      mosi_sync <= {mosi_sync[0], MOSI};

      if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
      if (arm_ok) armed <= 1'b1;

      // Leaving the frame discards any partial word.
      if (!in_frame)        bitcnt <= '0;
      else if (sample_edge) bitcnt <= (bitcnt == LAST_BIT) ? '0 : bitcnt + 1'b1;

      if (rx_shift_en) rx_shift <= {rx_shift[WIDTH-3:0], mosi_sync[1]};

      // A completing word wins over an accept in the same cycle: rx_valid
      // stays high with the new data, and the old word counts as consumed.
      if (word_done) begin
        rx_data  <= {rx_shift, mosi_sync[1]};
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (frame_start) rx_overrun <= 1'b0;

      if (tx_load) begin
        tx_shift  <= hold_full ? hold_data : fill_word;
        hold_full <= 1'b0;
      end else if (tx_shift_en) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end

      // Only an empty register accepts, so this never collides with the
      // emptying above; a load into an empty register in a load cycle wins.
      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      tx_underrun <= tx_load && !hold_full;
    end
  end

  assign MISO         = active && tx_shift[WIDTH-1];
  assign miso_oe      = active;
  assign frame_active = active;
  assign tx_ready     = !hold_full;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_ctrl
//   Directed bench for spi_slave_ctrl. Two instances share SCK/MOSI/rst_n and
//   have separate selects: dut0 is WIDTH=8 mode 0, dut3 is WIDTH=16 mode 3.
//   A behavioural master shifts words in and captures MISO on sample edges.
// -----------------------------------------------------------------------------
module tb_spi_slave_ctrl;

`ifdef SPI_SLAVE_CTRL_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n, sck, mosi, ssel0, ssel3;

  logic        miso0, miso_oe0, rx_valid0, rx_ready0, rx_overrun0;
  logic        tx_valid0, tx_ready0, tx_underrun0, frame_active0;
  logic [7:0]  rx_data0, tx_data0;

  logic        miso3, miso_oe3, rx_valid3, rx_ready3, rx_overrun3;
  logic        tx_valid3, tx_ready3, tx_underrun3, frame_active3;
  logic [15:0] rx_data3, tx_data3;

  logic [31:0] m_tx [2];
  logic [31:0] m_rx [2];
  logic [31:0] acc0_q [$];
  logic [31:0] acc3_q [$];
  int          und0 = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .SCK(sck), .SSEL(ssel0), .MOSI(mosi),
    .MISO(miso0), .miso_oe(miso_oe0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_ready(rx_ready0), .rx_overrun(rx_overrun0), .tx_data(tx_data0),
    .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_underrun(tx_underrun0),
    .frame_active(frame_active0)
  );

  spi_slave_ctrl #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .SCK(sck), .SSEL(ssel3), .MOSI(mosi),
    .MISO(miso3), .miso_oe(miso_oe3), .rx_data(rx_data3), .rx_valid(rx_valid3),
    .rx_ready(rx_ready3), .rx_overrun(rx_overrun3), .tx_data(tx_data3),
    .tx_valid(tx_valid3), .tx_ready(tx_ready3), .tx_underrun(tx_underrun3),
    .frame_active(frame_active3)
  );

  // Log every accepted word and every underrun pulse.
  always @(negedge clk) begin
    if (rx_valid0 && rx_ready0) acc0_q.push_back(32'(rx_data0));
    if (rx_valid3 && rx_ready3) acc3_q.push_back(32'(rx_data3));
    if (tx_underrun0) und0 = und0 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master frame: nwords words of width bits (or only nbits bits if nbits>0).
  // CPHA=0 frames end with SSEL raised while SCK is still active, so the
  // return of SCK to idle falls outside the frame.
  task automatic spi_xfer(input int sel, input int width, input bit cpol,
                          input bit cpha, input int nwords, input int nbits);
    int total;
    total   = (nbits > 0) ? nbits : nwords * width;
    m_rx[0] = '0;
    m_rx[1] = '0;
    sck     = cpol;
    if (sel == 0) ssel0 = 1'b0; else ssel3 = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < total; i++) begin
      int w, b;
      w = i / width;
      b = width - 1 - (i % width);
      if (!cpha) begin
        mosi = m_tx[w][b];
        wait_clk(HALF);
        m_rx[w][b] = (sel == 0) ? miso0 : miso3;
        sck = ~cpol;
        wait_clk(HALF);
        if (i != total - 1) sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = m_tx[w][b];
        wait_clk(HALF);
        m_rx[w][b] = (sel == 0) ? miso0 : miso3;
        sck = cpol;
        wait_clk(HALF);
      end
    end
    wait_clk(HALF);
    if (sel == 0) ssel0 = 1'b1; else ssel3 = 1'b1;
    wait_clk(HALF);
    sck = cpol;
    wait_clk(HALF);
  endtask

  initial begin
    int n0, n3, u0;
    rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; ssel0 = 1'b1; ssel3 = 1'b1;
    rx_ready0 = 1'b1; rx_ready3 = 1'b1;
    tx_valid0 = 1'b0; tx_valid3 = 1'b0; tx_data0 = '0; tx_data3 = '0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(8);

    // Reset state.
    check("rst_miso",      32'(miso0),         32'h0);
    check("rst_miso_oe",   32'(miso_oe0),      32'h0);
    check("rst_rx_data",   32'(rx_data0),      32'h0);
    check("rst_rx_valid",  32'(rx_valid0),     32'h0);
    check("rst_overrun",   32'(rx_overrun0),   32'h0);
    check("rst_tx_ready",  32'(tx_ready0),     32'h1);
    check("rst_underrun",  32'(tx_underrun0),  32'h0);
    check("rst_frame",     32'(frame_active0), 32'h0);
    check("rst3_rx_data",  32'(rx_data3),      32'h0);
    check("rst3_tx_ready", 32'(tx_ready3),     32'h1);
    check("rst3_miso_oe",  32'(miso_oe3 | miso3 | frame_active3 | tx_underrun3 | rx_valid3), 32'h0);

    // Underrun: no tx word offered, two words in one frame.
    u0 = und0; n0 = acc0_q.size();
    m_tx[0] = 32'h5A; m_tx[1] = 32'h77;
    spi_xfer(0, 8, 1'b0, 1'b0, 2, 0);
    check("und_miso_w0", m_rx[0], 32'h00);
    check("und_miso_w1", m_rx[1], ECHO ? 32'h5A : 32'h00);
    check("und_pulses",  32'(und0 - u0), 32'd2);
    check("und_rx_cnt",  32'(acc0_q.size() - n0), 32'd2);
    if (acc0_q.size() >= n0 + 2) begin
      check("und_rx_w0", acc0_q[n0],     32'h5A);
      check("und_rx_w1", acc0_q[n0 + 1], 32'h77);
    end

    // Mode 0 single word with tx preloaded.
    @(negedge clk);
    tx_data0 = 8'hA5; tx_valid0 = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b0;
    check("pre_tx_ready", 32'(tx_ready0), 32'h0);
    u0 = und0; n0 = acc0_q.size();
    m_tx[0] = 32'h3C;
    spi_xfer(0, 8, 1'b0, 1'b0, 1, 0);
    check("m0_master_rx", m_rx[0], 32'hA5);
    check("m0_rx_data",   32'(rx_data0), 32'h3C);
    check("m0_rx_cnt",    32'(acc0_q.size() - n0), 32'd1);
    check("m0_tx_ready",  32'(tx_ready0), 32'h1);
    check("m0_underrun",  32'(und0 - u0), 32'd0);
    if (acc0_q.size() > n0) check("m0_rx_word", acc0_q[n0], 32'h3C);

    // Overrun with consumer stalled, cleared by the next frame start.
    rx_ready0 = 1'b0;
    m_tx[0] = 32'h11; m_tx[1] = 32'h22;
    spi_xfer(0, 8, 1'b0, 1'b0, 2, 0);
    check("ovr_rx_data",  32'(rx_data0),    32'h22);
    check("ovr_rx_valid", 32'(rx_valid0),   32'h1);
    check("ovr_flag",     32'(rx_overrun0), 32'h1);
    ssel0 = 1'b0;
    wait_clk(HALF);
    check("ovr_clear",    32'(rx_overrun0), 32'h0);
    ssel0 = 1'b1;
    wait_clk(HALF);
    rx_ready0 = 1'b1;
    wait_clk(3);
    check("ovr_drained",  32'(rx_valid0),   32'h0);

    // Partial word discarded, then a full frame.
    n0 = acc0_q.size();
    m_tx[0] = 32'hF0;
    spi_xfer(0, 8, 1'b0, 1'b0, 1, 5);
    check("part_no_rx",    32'(acc0_q.size() - n0), 32'd0);
    check("part_rx_valid", 32'(rx_valid0), 32'h0);
    m_tx[0] = 32'hC3;
    spi_xfer(0, 8, 1'b0, 1'b0, 1, 0);
    check("part_rx_data",  32'(rx_data0), 32'hC3);
    check("part_rx_cnt",   32'(acc0_q.size() - n0), 32'd1);

    // Reset pulse mid-word.
    ssel0 = 1'b0; mosi = 1'b1; sck = 1'b0;
    wait_clk(HALF);
    tx_data0 = 8'h99; tx_valid0 = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b0;
    sck = 1'b1; wait_clk(HALF);
    sck = 1'b0; wait_clk(HALF);
    sck = 1'b1; wait_clk(HALF);
    check("mid_tx_ready", 32'(tx_ready0), 32'h0);
    check("mid_frame",    32'(frame_active0), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mr_rx_data",  32'(rx_data0),    32'h0);
    check("mr_tx_ready", 32'(tx_ready0),   32'h1);
    check("mr_miso_oe",  32'(miso_oe0),    32'h0);
    check("mr_frame",    32'(frame_active0), 32'h0);
    check("mr_miso",     32'(miso0 | rx_valid0 | rx_overrun0 | tx_underrun0), 32'h0);
    n0 = acc0_q.size();
    sck = 1'b0; wait_clk(HALF);
    sck = 1'b1; wait_clk(HALF);
    check("mr_ignored",  32'(frame_active0), 32'h0);
    ssel0 = 1'b1; wait_clk(HALF);
    sck = 1'b0;   wait_clk(HALF);
    check("mr_no_rx",    32'(acc0_q.size() - n0), 32'd0);
    m_tx[0] = 32'h6B;
    spi_xfer(0, 8, 1'b0, 1'b0, 1, 0);
    check("mr_rx_after", 32'(rx_data0), 32'h6B);
    check("mr_rx_cnt",   32'(acc0_q.size() - n0), 32'd1);
    check("mr_master",   m_rx[0], 32'h00);

    // WIDTH=16 mode 3, two words, consumer always ready.
    sck = 1'b1;
    wait_clk(HALF);
    n3 = acc3_q.size();
    m_tx[0] = 32'h1234; m_tx[1] = 32'hBEEF;
    spi_xfer(1, 16, 1'b1, 1'b1, 2, 0);
    check("m3_rx_cnt",   32'(acc3_q.size() - n3), 32'd2);
    if (acc3_q.size() >= n3 + 2) begin
      check("m3_rx_w0", acc3_q[n3],     32'h1234);
      check("m3_rx_w1", acc3_q[n3 + 1], 32'hBEEF);
    end
    check("m3_overrun",  32'(rx_overrun3), 32'h0);
    check("m3_rx_data",  32'(rx_data3),    32'hBEEF);
    check("m3_master0",  m_rx[0], 32'h0000);
    check("m3_master1",  m_rx[1], ECHO ? 32'h1234 : 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
